mem_interface: RTL and testbench
================================

Name: mem_interface

Overview:
- Memory-side stage that produces mdatain for the memory data register and commits register contents to memory.
- Holds a synchronous word-addressed RAM and runs a read/write FSM with a programmable wait-state counter.
- Generates the MDR's read-select and load strobe for exactly one cycle per read, plus a done/err handshake back to the control unit.
- Consumes the MAR address and the MDR output q as write data.

Parameters:
- DATA_WIDTH, 32, word width of RAM, write data and mdatain
- ADDR_WIDTH, 9, address width; RAM depth is 2**ADDR_WIDTH words
- WAIT_STATES, 2, idle cycles between request acceptance and the transfer cycle (0..15)

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- clear  input  1  asynchronous, active-high reset
- mar_addr  input  ADDR_WIDTH  word address from the MAR
- mdr_q  input  DATA_WIDTH  write data from the MDR output
- read_req  input  1  read request, sampled only in IDLE
- write_req  input  1  write request, sampled only in IDLE
- mdatain  output  DATA_WIDTH  read data to the MDR mux input
- mdr_read  output  1  MDR mux select (1 = take mdatain)
- mdr_load  output  1  MDR load enable, driven to the MDR's mdrin
- busy  output  1  high while an access is in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset (clear=1, async):
  - State goes to IDLE; wait counter, latched address and latched data all go to 0.
  - mdatain=0; mdr_read, mdr_load, busy, done and err are all 0.
  - RAM contents are not cleared.
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - read_req xor write_req at a rising edge: latch mar_addr, mdr_q and the op; load counter with WAIT_STATES.
  - Next state is WAIT, or XFER if WAIT_STATES=0.
  - read_req and write_req both 1: no access, no RAM change; next state DONE with the err flag set.
  - Neither request: stay in IDLE.
- WAIT:
  - busy=1; counter decrements each cycle.
  - Moves to XFER on the edge where the counter equals 1.
  - Exactly WAIT_STATES cycles are spent in WAIT.
- XFER (exactly one cycle): busy=1.
  - Read: mdatain = RAM[latched addr]; mdr_read=1; mdr_load=1. The MDR captures on the closing edge of XFER.
  - Write: RAM[latched addr] <= latched data on the closing edge of XFER. mdr_read=0, mdr_load=0.
- DONE (exactly one cycle): done=1; err=1 only for the both-requests case; busy=0. Next state IDLE.
- Requests arriving in WAIT, XFER or DONE are ignored; the requester must hold or re-present them in IDLE.
- Outside a read XFER: mdatain=0, mdr_read=0, mdr_load=0.
- Latency, counted from the acceptance edge E0:
  - Transfer occurs at edge E0+WAIT_STATES+1.
  - done is high during the cycle between edges E0+WAIT_STATES+1 and E0+WAIT_STATES+2.
  - Next acceptance is possible at edge E0+WAIT_STATES+3.
- Address and data are latched at acceptance. Changes on mar_addr or mdr_q during the access have no effect.
- Reset mid-access: the access is aborted immediately. A write not yet at its XFER closing edge is not committed. No done pulse is issued.
- Address wrap: not applicable; every ADDR_WIDTH value maps to a RAM word.

Test Plan:
- Reset value check: assert clear, then release; apply no requests for 5 cycles -> all outputs remain 0 and state stays IDLE.
- Write then read, WAIT_STATES=2:
  - write_req with mar_addr=0x05, mdr_q=0xDEADBEEF -> done pulses 4 cycles after acceptance, with no mdr_load.
  - read_req with addr 0x05 -> exactly one cycle of mdr_read=1, mdr_load=1, mdatain=0xDEADBEEF, 3 cycles after acceptance; done on the next cycle.
- Hold stability: change mar_addr to 0x06 and mdr_q to 0 during WAIT of a write to 0x07 with data 0x12345678 -> a read of 0x07 returns 0x12345678, and 0x06 is unchanged.
- Conflict: read_req=write_req=1 in IDLE -> done=1 and err=1 for one cycle after acceptance; RAM unchanged; mdr_load never asserted.
- Abort: clear pulsed during WAIT of a write of 0xAAAA5555 to 0x10 (RAM previously 0x11111111) -> outputs go to 0 asynchronously; a read of 0x10 returns 0x11111111; no done.
- WAIT_STATES=0 instance: back-to-back reads of 0x00 then 0x01 with requests held high -> XFER on the cycle after each acceptance; accepts are 3 cycles apart; mdatain values match RAM.

Source files
------------

// File: rtl/mem_interface.sv
// mem_interface: memory-side stage between the MAR/MDR and a synchronous
// word-addressed RAM. A four-state FSM runs each access: IDLE, then a
// programmable number of WAIT cycles, then one XFER cycle, then one DONE cycle.
// On a read, XFER drives the MDR mux select and load strobe. On a write, the
// RAM is written on the clock edge that ends XFER.
module mem_interface #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] mar_addr,
    input  logic [DATA_WIDTH-1:0] mdr_q,
    input  logic                  read_req,
    input  logic                  write_req,
    output logic [DATA_WIDTH-1:0] mdatain,
    output logic                  mdr_read,
    output logic                  mdr_load,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                  state, state_next;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    op_write;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic accept;
    logic conflict;

    // A request counts only in IDLE, and only when exactly one request line is high.
    assign accept   = (state == S_IDLE) && (read_req ^ write_req);
    assign conflict = (state == S_IDLE) && read_req && write_req;

    // The read is fetched on the edge that enters XFER. When WAIT_STATES is 0,
    // that edge is the acceptance edge, and the address is not latched yet.
    assign rd_addr = (state == S_IDLE) ? mar_addr : addr_q;

    // State register; clear aborts any access in flight.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            // NOTE: all clocked state uses non-blocking assignments, so every
            // register samples the values that were present before the edge.
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the address, data and operation at acceptance, and run the wait counter.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wait_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            op_write <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                err_q <= conflict;
            end
            if (accept) begin
                addr_q   <= mar_addr;
                data_q   <= mdr_q;
                op_write <= write_req;
                wait_cnt <= WAIT_INIT;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        // NOTE: the default is assigned first, so every path assigns
        // state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (WAIT_INIT == 4'd0) ? S_XFER : S_WAIT;
                end else if (conflict) begin
                    state_next = S_DONE;
                end
            end
            S_WAIT:  if (wait_cnt == 4'd1) state_next = S_XFER;
            S_XFER:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // RAM port: commit a write when XFER closes, and fetch read data when XFER opens.
    always_ff @(posedge clock) begin
        // NOTE: the RAM array has no reset, so its contents survive clear.
        // Writes are gated by state, and state does reset.
        if (state == S_XFER && op_write) begin
            mem[addr_q] <= data_q;
        end
        if (state_next == S_XFER) begin
            rd_data <= mem[rd_addr];
        end
    end

    assign mdr_read = (state == S_XFER) && !op_write;
    assign mdr_load = mdr_read;
    assign mdatain  = mdr_read ? rd_data : '0;
    assign busy     = (state == S_WAIT) || (state == S_XFER);
    assign done     = (state == S_DONE);
    assign err      = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed testbench for mem_interface. It drives one instance with
// WAIT_STATES=2 and one with WAIT_STATES=0. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_mem_interface;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          clear = 1'b0;

    logic [AW-1:0] mar_addr  = '0;
    logic [DW-1:0] mdr_q     = '0;
    logic          read_req  = 1'b0;
    logic          write_req = 1'b0;
    logic [DW-1:0] mdatain;
    logic          mdr_read, mdr_load, busy, done, err;

    logic [AW-1:0] mar_addr0  = '0;
    logic [DW-1:0] mdr_q0     = '0;
    logic          read_req0  = 1'b0;
    logic          write_req0 = 1'b0;
    logic [DW-1:0] mdatain0;
    logic          mdr_read0, mdr_load0, busy0, done0, err0;

    int checks = 0;
    int errors = 0;

    mem_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(2)) dut (
        .clock(clock), .clear(clear), .mar_addr(mar_addr), .mdr_q(mdr_q),
        .read_req(read_req), .write_req(write_req), .mdatain(mdatain),
        .mdr_read(mdr_read), .mdr_load(mdr_load), .busy(busy), .done(done), .err(err)
    );

    mem_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clock(clock), .clear(clear), .mar_addr(mar_addr0), .mdr_q(mdr_q0),
        .read_req(read_req0), .write_req(write_req0), .mdatain(mdatain0),
        .mdr_read(mdr_read0), .mdr_load(mdr_load0), .busy(busy0), .done(done0), .err(err0)
    );

    always #5 clock = ~clock;

    // Stimulus helper for the WAIT_STATES=2 instance; it makes no comparisons.
    // It presents one request for a single edge (E0), then switches the
    // address and data lines to alt values. It then traces the outputs for 8
    // cycles; cycle c is the falling edge between edges E0+c and E0+c+1.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [AW-1:0] alt_a, input logic [DW-1:0] alt_d,
                              output int load_cnt, output int load_cyc,
                              output logic [DW-1:0] rdata,
                              output int done_cnt, output int done_cyc,
                              output logic err_seen, output int busy_cnt,
                              output int odd_cnt);
        load_cnt = 0; load_cyc = -1; rdata = '0;
        done_cnt = 0; done_cyc = -1; err_seen = 1'b0;
        busy_cnt = 0; odd_cnt = 0;
        @(negedge clock);
        read_req = rd; write_req = wr; mar_addr = a; mdr_q = d;
        @(posedge clock);
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (mdr_load) begin
                load_cnt++; load_cyc = c; rdata = mdatain;
            end else if (mdatain !== '0) begin
                odd_cnt++;
            end
            if (mdr_read !== mdr_load) odd_cnt++;
            if (done) begin
                done_cnt++; done_cyc = c; err_seen = err;
            end else if (err) begin
                odd_cnt++;
            end
            if (busy) busy_cnt++;
            if (busy && done) odd_cnt++;
            if (c == 0) begin
                read_req = 1'b0; write_req = 1'b0; mar_addr = alt_a; mdr_q = alt_d;
            end
        end
    endtask

    task automatic test_reset();
        #2 clear = 1'b1;
        #1;
        checks++;
        if ({mdatain, mdr_read, mdr_load, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_during_clear got %h expected 0",
                     {mdatain, mdr_read, mdr_load, busy, done, err});
        end
        repeat (2) @(negedge clock);
        clear = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if ({mdatain, mdr_read, mdr_load, busy, done, err} !== '0) begin
                errors++;
                $display("FAIL reset_idle_cycle%0d got %h expected 0", c,
                         {mdatain, mdr_read, mdr_load, busy, done, err});
            end
        end
    endtask

    task automatic test_write_read();
        int lc, lcy, dc, dcy, bc, oc;
        logic [DW-1:0] rd;
        logic es;
        run_access(1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 9'h005, 32'hDEADBEEF,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        checks++;
        if (dc !== 1 || dcy !== 3) begin
            errors++; $display("FAIL wr_done got count %0d cycle %0d expected 1 at 3", dc, dcy);
        end
        checks++;
        if (lc !== 0) begin
            errors++; $display("FAIL wr_no_load got %0d expected 0", lc);
        end
        checks++;
        if (bc !== 3 || es !== 1'b0 || oc !== 0) begin
            errors++; $display("FAIL wr_busy_err got busy %0d err %b odd %0d expected 3 0 0", bc, es, oc);
        end
        run_access(1'b1, 1'b0, 9'h005, 32'h0, 9'h005, 32'h0,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        checks++;
        if (lc !== 1 || lcy !== 2) begin
            errors++; $display("FAIL rd_load got count %0d cycle %0d expected 1 at 2", lc, lcy);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_data got %h expected deadbeef", rd);
        end
        checks++;
        if (dc !== 1 || dcy !== 3 || es !== 1'b0 || oc !== 0) begin
            errors++; $display("FAIL rd_done got count %0d cycle %0d err %b odd %0d expected 1 3 0 0",
                               dc, dcy, es, oc);
        end
    endtask

    task automatic test_hold();
        int lc, lcy, dc, dcy, bc, oc;
        logic [DW-1:0] rd;
        logic es;
        run_access(1'b0, 1'b1, 9'h006, 32'hCAFEF00D, 9'h006, 32'hCAFEF00D,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        run_access(1'b0, 1'b1, 9'h007, 32'h12345678, 9'h006, 32'h0,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        run_access(1'b1, 1'b0, 9'h007, 32'h0, 9'h007, 32'h0,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        checks++;
        if (lc !== 1 || rd !== 32'h12345678) begin
            errors++; $display("FAIL hold_addr7 got %h (loads %0d) expected 12345678", rd, lc);
        end
        run_access(1'b1, 1'b0, 9'h006, 32'h0, 9'h006, 32'h0,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        checks++;
        if (lc !== 1 || rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL hold_addr6 got %h (loads %0d) expected cafef00d", rd, lc);
        end
    endtask

    task automatic test_conflict();
        int lc, lcy, dc, dcy, bc, oc;
        logic [DW-1:0] rd;
        logic es;
        run_access(1'b1, 1'b1, 9'h005, 32'h0BADF00D, 9'h005, 32'h0BADF00D,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        checks++;
        if (dc !== 1 || dcy !== 0 || es !== 1'b1) begin
            errors++; $display("FAIL conflict_done got count %0d cycle %0d err %b expected 1 0 1", dc, dcy, es);
        end
        checks++;
        if (lc !== 0 || bc !== 0 || oc !== 0) begin
            errors++; $display("FAIL conflict_quiet got loads %0d busy %0d odd %0d expected 0 0 0", lc, bc, oc);
        end
        run_access(1'b1, 1'b0, 9'h005, 32'h0, 9'h005, 32'h0,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        checks++;
        if (rd !== 32'hDEADBEEF || es !== 1'b0) begin
            errors++; $display("FAIL conflict_ram got %h err %b expected deadbeef 0", rd, es);
        end
    endtask

    task automatic test_abort();
        int lc, lcy, dc, dcy, bc, oc, nd;
        logic [DW-1:0] rd;
        logic es;
        run_access(1'b0, 1'b1, 9'h010, 32'h11111111, 9'h010, 32'h11111111,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        @(negedge clock);
        write_req = 1'b1; mar_addr = 9'h010; mdr_q = 32'hAAAA5555;
        @(posedge clock);
        @(negedge clock);
        write_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL abort_in_wait got busy %b expected 1", busy);
        end
        #2 clear = 1'b1;
        #1;
        checks++;
        if ({mdatain, mdr_read, mdr_load, busy, done, err} !== '0) begin
            errors++; $display("FAIL abort_async got %h expected 0",
                               {mdatain, mdr_read, mdr_load, busy, done, err});
        end
        @(negedge clock);
        clear = 1'b0;
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (done || busy) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++; $display("FAIL abort_no_done got %0d active cycles expected 0", nd);
        end
        run_access(1'b1, 1'b0, 9'h010, 32'h0, 9'h010, 32'h0,
                   lc, lcy, rd, dc, dcy, es, bc, oc);
        checks++;
        if (lc !== 1 || rd !== 32'h11111111) begin
            errors++; $display("FAIL abort_ram got %h (loads %0d) expected 11111111", rd, lc);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [2];
        int lcyc [2];
        logic [DW-1:0] ldat [2];
        int dcyc [2];
        int nl, ndn;
        vals[0] = 32'hA0A0A0A0;
        vals[1] = 32'h01010101;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            write_req0 = 1'b1; mar_addr0 = AW'(i); mdr_q0 = vals[i];
            @(posedge clock);
            @(negedge clock);
            write_req0 = 1'b0;
            checks++;
            if (busy0 !== 1'b1 || mdr_load0 !== 1'b0 || mdr_read0 !== 1'b0) begin
                errors++; $display("FAIL ws0_write%0d_xfer got busy %b load %b read %b expected 1 0 0",
                                   i, busy0, mdr_load0, mdr_read0);
            end
            @(negedge clock);
            checks++;
            if (done0 !== 1'b1 || err0 !== 1'b0) begin
                errors++; $display("FAIL ws0_write%0d_done got done %b err %b expected 1 0", i, done0, err0);
            end
        end
        nl = 0; ndn = 0;
        lcyc[0] = -1; lcyc[1] = -1; dcyc[0] = -1; dcyc[1] = -1;
        ldat[0] = '0; ldat[1] = '0;
        @(negedge clock);
        read_req0 = 1'b1; mar_addr0 = 9'h000;
        @(posedge clock);
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            if (mdr_load0) begin
                if (nl < 2) begin
                    lcyc[nl] = c; ldat[nl] = mdatain0;
                end
                nl++;
                mar_addr0 = 9'h001;
            end
            if (done0) begin
                if (ndn < 2) dcyc[ndn] = c;
                ndn++;
            end
            if (c == 3) read_req0 = 1'b0;
        end
        checks++;
        if (nl !== 2 || lcyc[0] !== 0 || lcyc[1] !== 3) begin
            errors++; $display("FAIL b2b_xfer_cycles got count %0d at %0d,%0d expected 2 at 0,3",
                               nl, lcyc[0], lcyc[1]);
        end
        checks++;
        if (ldat[0] !== 32'hA0A0A0A0 || ldat[1] !== 32'h01010101) begin
            errors++; $display("FAIL b2b_data got %h,%h expected a0a0a0a0,01010101", ldat[0], ldat[1]);
        end
        checks++;
        if (ndn !== 2 || dcyc[0] !== 1 || dcyc[1] !== 4) begin
            errors++; $display("FAIL b2b_done got count %0d at %0d,%0d expected 2 at 1,4",
                               ndn, dcyc[0], dcyc[1]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_conflict();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
